// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared sizes and helpers for the writeback port arbiter
// Contents: NUM_REQ / DATA_WIDTH / TAG_WIDTH, clog2() and the derived
// round-robin pointer width PTR_W.
package wb_arb_pkg;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH  = 6;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int PTR_W = clog2(NUM_REQ);

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - requester and write-port bundle for the writeback arbiter
// Signals: stall_i, req_valid_i/req_tag_i/req_data_i (flattened, req i at
// [i*W +: W]), req_ready_o, write1_*/write2_* registered port outputs.
// slave modport = arbiter side, master modport = requesters/storage side.
interface wb_port_arbiter_if;
  import wb_arb_pkg::*;

  logic                          stall_i;
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          write1_en_o;
  logic [TAG_WIDTH-1:0]          write1_tag_o;
  logic [DATA_WIDTH-1:0]         write1_data_o;
  logic                          write2_en_o;
  logic [TAG_WIDTH-1:0]          write2_tag_o;
  logic [DATA_WIDTH-1:0]         write2_data_o;

  modport slave (
    input  stall_i, req_valid_i, req_tag_i, req_data_i,
    output req_ready_o,
    output write1_en_o, write1_tag_o, write1_data_o,
    output write2_en_o, write2_tag_o, write2_data_o
  );

  modport master (
    output stall_i, req_valid_i, req_tag_i, req_data_i,
    input  req_ready_o,
    input  write1_en_o, write1_tag_o, write1_data_o,
    input  write2_en_o, write2_tag_o, write2_data_o
  );

endinterface

// File: rtl/rr_dual_picker.sv
// rtl/rr_dual_picker.sv - combinational round-robin picker of two distinct-tag requests
// Ports: valid (NUM_REQ), tags (flattened), rr_ptr in; a_vld/a_idx (first valid
// from rr_ptr), b_vld/b_idx (next valid after A whose tag differs from A's) out.
module rr_dual_picker
  import wb_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0]           valid,
  input  logic [NUM_REQ*TAG_WIDTH-1:0] tags,
  input  logic [PTR_W-1:0]             rr_ptr,
  output logic                         a_vld,
  output logic [PTR_W-1:0]             a_idx,
  output logic                         b_vld,
  output logic [PTR_W-1:0]             b_idx
);

  logic [TAG_WIDTH-1:0] a_tag;
  logic [TAG_WIDTH-1:0] cur_tag;
  int                   idx;

  // Walk the requesters in priority order starting at rr_ptr. Requests that
  // share A's tag are skipped so the two ports never target the same register.
  always_comb begin
    a_vld   = 1'b0;
    a_idx   = '0;
    b_vld   = 1'b0;
    b_idx   = '0;
    a_tag   = '0;
    cur_tag = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx     = (int'(rr_ptr) + k) % NUM_REQ;
      cur_tag = tags[idx*TAG_WIDTH +: TAG_WIDTH];
      if (valid[idx]) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = PTR_W'(idx);
          a_tag = cur_tag;
        end else if (!b_vld && (cur_tag != a_tag)) begin
          b_vld = 1'b1;
          b_idx = PTR_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin arbiter sharing two register-file write ports
// Ports: clk, rst (sync, active-low), bus (wb_port_arbiter_if.slave).
// Grants up to two requests per cycle (slot A -> port 1, slot B -> port 2);
// the granted writes appear on the registered port outputs one cycle later.
module wb_port_arbiter
  import wb_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  wb_port_arbiter_if.slave bus
);

  logic [PTR_W-1:0] rr_ptr;
  logic             a_vld;
  logic             b_vld;
  logic [PTR_W-1:0] a_idx;
  logic [PTR_W-1:0] b_idx;
  logic [PTR_W-1:0] last_idx;
  logic             grant_ok;

  rr_dual_picker u_picker (
    .valid  (bus.req_valid_i),
    .tags   (bus.req_tag_i),
    .rr_ptr (rr_ptr),
    .a_vld  (a_vld),
    .a_idx  (a_idx),
    .b_vld  (b_vld),
    .b_idx  (b_idx)
  );

  // Reset wins over any pending grant, so requesters retry after release.
  assign grant_ok = rst & ~bus.stall_i;

  always_comb begin
    bus.req_ready_o = '0;
    if (grant_ok) begin
      if (a_vld) bus.req_ready_o[a_idx] = 1'b1;
      if (b_vld) bus.req_ready_o[b_idx] = 1'b1;
    end
  end

  // B always follows A in scan order, so it is the last granted index when present.
  assign last_idx = b_vld ? b_idx : a_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr            <= '0;
      bus.write1_en_o   <= 1'b0;
      bus.write1_tag_o  <= '0;
      bus.write1_data_o <= '0;
      bus.write2_en_o   <= 1'b0;
      bus.write2_tag_o  <= '0;
      bus.write2_data_o <= '0;
    end else begin
      bus.write1_en_o <= grant_ok & a_vld;
      bus.write2_en_o <= grant_ok & b_vld;
      if (grant_ok && a_vld) begin
        bus.write1_tag_o  <= bus.req_tag_i[a_idx*TAG_WIDTH +: TAG_WIDTH];
        bus.write1_data_o <= bus.req_data_i[a_idx*DATA_WIDTH +: DATA_WIDTH];
        rr_ptr            <= (last_idx == PTR_W'(NUM_REQ-1)) ? '0 : last_idx + 1'b1;
      end
      if (grant_ok && b_vld) begin
        bus.write2_tag_o  <= bus.req_tag_i[b_idx*TAG_WIDTH +: TAG_WIDTH];
        bus.write2_data_o <= bus.req_data_i[b_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule
